// File: rtl/nios2_mul_pkg.sv
// Shared constants and the in-flight token type for the Nios II multiply issue/retire controller.
package nios2_mul_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_TAG_W      = 5;
  localparam int MAX_FIFO_DEPTH = 8;
  // Wide enough to hold any legal FIFO_DEPTH as a count (0..depth inclusive).
  localparam int CNT_W          = $clog2(MAX_FIFO_DEPTH + 1);

  typedef struct packed {
    logic                 valid;
    logic [DEF_TAG_W-1:0] tag;
  } mul_token_t;

endpackage

// File: rtl/nios2_mul_result_fifo.sv
// Synchronous result/tag FIFO with modulo-depth pointers; clear drops contents, reset also zeroes storage.
module nios2_mul_result_fifo
  import nios2_mul_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int TAG_W  = DEF_TAG_W,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              i_rst,
  input  logic              i_clr,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic [TAG_W-1:0]  o_tag,
  output logic              o_full,
  output logic              o_empty,
  output logic [CNT_W-1:0]  o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] r_data [DEPTH];
  logic [TAG_W-1:0]  r_tag  [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_count = r_count;
  assign o_data  = r_data[r_rd_ptr];
  assign o_tag   = r_tag[r_rd_ptr];
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_tag[i]  <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_data[r_wr_ptr] <= i_data;
        r_tag[r_wr_ptr]  <= i_tag;
        r_wr_ptr         <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      if (i_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!i_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/nios2_mul_issue_ctrl.sv
// Issue/retire controller for the hardware multiply cell: registered operands, latency-matched
// tag pipeline and a credit-gated result FIFO so no product is ever dropped.
module nios2_mul_issue_ctrl
  import nios2_mul_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int TAG_W       = DEF_TAG_W,
  parameter int MUL_LATENCY = 1,
  parameter int FIFO_DEPTH  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  input  logic [TAG_W-1:0]  in_tag,
  output logic [DATA_W-1:0] mul_src1,
  output logic [DATA_W-1:0] mul_src2,
  input  logic [DATA_W-1:0] mul_cell_result,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy
);

  // Stage 0 sits alongside the operand registers; the cell adds MUL_LATENCY more edges.
  mul_token_t        r_tok_p [MUL_LATENCY+1];
  logic [CNT_W-1:0]  r_inflight_cnt;
  logic [DATA_W-1:0] r_src1;
  logic [DATA_W-1:0] r_src2;

  logic              w_accept;
  logic              w_retire;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [CNT_W-1:0]  w_fifo_cnt;
  logic [CNT_W:0]    w_credit_used;

  // Credits come only from registered counts, so a pop frees its slot one cycle later.
  assign w_credit_used = {1'b0, r_inflight_cnt} + {1'b0, w_fifo_cnt};
  assign in_ready      = !reset && !flush && !w_fifo_full &&
                         (w_credit_used < (CNT_W+1)'(FIFO_DEPTH));
  assign w_accept      = in_valid && in_ready;
  assign w_retire      = r_tok_p[MUL_LATENCY].valid;

  assign mul_src1  = r_src1;
  assign mul_src2  = r_src2;
  assign out_valid = !w_fifo_empty;
  assign busy      = (r_inflight_cnt != '0) || (w_fifo_cnt != '0);

  // Operand registers hold between accepts so the cell inputs do not toggle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_src1 <= '0;
      r_src2 <= '0;
    end else if (w_accept) begin
      r_src1 <= in_src1;
      r_src2 <= in_src2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      for (int i = 0; i <= MUL_LATENCY; i++) begin
        r_tok_p[i] <= '0;
      end
      r_inflight_cnt <= '0;
    end else begin
      r_tok_p[0].valid <= w_accept;
      r_tok_p[0].tag   <= in_tag;
      for (int i = 1; i <= MUL_LATENCY; i++) begin
        r_tok_p[i] <= r_tok_p[i-1];
      end
      r_inflight_cnt <= r_inflight_cnt + CNT_W'(w_accept) - CNT_W'(w_retire);
    end
  end

  nios2_mul_result_fifo #(
    .DATA_W (DATA_W),
    .TAG_W  (TAG_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .i_rst   (reset),
    .i_clr   (flush),
    .i_push  (w_retire),
    .i_data  (mul_cell_result),
    .i_tag   (r_tok_p[MUL_LATENCY].tag),
    .i_pop   (out_ready),
    .o_data  (out_result),
    .o_tag   (out_tag),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_cnt)
  );

endmodule

// File: doc/nios2_mul_issue_ctrl.md
# nios2_mul_issue_ctrl

Issue/retire controller for the Nios II hardware multiply cell. Accepts multiply requests from the execute stage on a valid/ready handshake and drives the cell's two 32-bit operand inputs from registers. It tracks each product through the cell's fixed pipeline latency, then buffers results with their destination tags in a small FIFO until writeback accepts them. Credit-based issue guarantees that no result is ever dropped.

## Interface
Parameters:
- DATA_W, 32: operand and result width.
- TAG_W, 5: destination-register tag width.
- MUL_LATENCY, 1: clock edges from operands presented on mul_src* to a valid mul_cell_result. Legal range 1..4.
- FIFO_DEPTH, 2: result buffer entries; also the total outstanding-request credit. Legal range 2..8.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- flush  in  1  synchronous; discards in-flight and buffered results.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid && in_ready at an edge.
- in_src1, in_src2  in  DATA_W  operands.
- in_tag  in  TAG_W  destination tag.
- mul_src1, mul_src2  out  DATA_W  registered operands to the multiply cell.
- mul_cell_result  in  DATA_W  low DATA_W bits of product from the cell.
- out_valid  out  1  result FIFO non-empty.
- out_ready  in  1  consumer pops when out_valid && out_ready.
- out_result  out  DATA_W  FIFO head result.
- out_tag  out  TAG_W  FIFO head tag.
- busy  out  1  any request in flight or buffered.

## Operation
- Accept: operands load into mul_src1/mul_src2 registers. A tag/valid token enters a MUL_LATENCY-stage shift pipeline. Without an accept, mul_src* hold their last value (no toggling).
- Retire: when a token leaves the pipeline, mul_cell_result and the token's tag are pushed into the FIFO on that same edge.
- Credits: in_ready = (inflight_cnt + fifo_cnt) < FIFO_DEPTH. It is computed from registered counts only, with no combinational path from out_ready or in_valid. A pop frees its credit one cycle later.
- FIFO overflow is impossible by construction. A push into a full FIFO is an assertion failure in the bench.
- Simultaneous push and pop: both occur and fifo_cnt is unchanged. Read/write pointers wrap modulo FIFO_DEPTH.
- Arithmetic: out_result is the unsigned product src1*src2 mod 2^DATA_W. This equals the signed low word. There is no overflow flag.
- flush or reset:
  - Clears pipeline tokens, FIFO pointers and counts.
  - An in_valid in the same cycle is not accepted, because in_ready is forced low during flush/reset.
  - A product already inside the cell is ignored, since its token was cleared.
- Results leave in issue order. Tags are opaque and pass through unchanged.

## Timing
- Reset values:
  - in_ready = 0 while reset is high, and 1 in the first cycle after reset deasserts.
  - out_valid = 0, busy = 0, mul_src1 = mul_src2 = 0.
  - out_result and out_tag = 0 (FIFO storage cleared).
- Latency: a request accepted at edge E0 appears with out_valid = 1 in the cycle after edge E(MUL_LATENCY+1). With the default latency, out_valid is high 2 cycles after the accept cycle.
- Throughput: one accept per cycle while credits remain. With out_ready held high and FIFO_DEPTH ≥ MUL_LATENCY+2, back-to-back accepts sustain indefinitely. Smaller depths throttle in_ready.
- out_valid, out_result and out_tag are stable while out_valid && !out_ready.
- busy = (inflight_cnt != 0) || (fifo_cnt != 0), registered-derived.

## Structure
- Shared package nios2_mul_pkg holds:
  - DATA_W and TAG_W defaults.
  - A clog2-based count-width constant for FIFO_DEPTH+1.
  - The token typedef {valid, tag}.
- Natural sub-module: nios2_mul_result_fifo, a parameterised sync FIFO with push, pop, full, empty, count and synchronous clear. It is instantiated once.
- The latency pipeline and credit counter stay in the top level.

## Test plan
- Single op: src1 = 3, src2 = 5, tag = 7 after reset. Expect out_result = 15, out_tag = 7 and out_valid in the cycle after E2. busy then falls after the pop.
- Wrap cases, issued back to back with out_ready high:
  - 0xFFFFFFFF × 0xFFFFFFFF gives 0x00000001.
  - 0x00010000 × 0x00010000 gives 0x00000000.
  - 0x12345678 × 9 gives 0xA3D70A38.
  - Results must come out in order with tags 1, 2, 3.
- Backpressure: out_ready = 0 with continuous in_valid. Expect exactly FIFO_DEPTH accepts and then in_ready = 0, with out_result stable. Raising out_ready drains the entries in order, and in_ready returns one cycle after the first pop.
- Simultaneous push/pop: FIFO holds one entry while a retire and a pop occur on the same edge. Expect fifo_cnt unchanged and the correct head ordering.
- Flush mid-operation: assert flush for one cycle with one op in flight and one buffered, plus in_valid high. Expect no output ever for the flushed ops, and the concurrent request not accepted. The next op, 6 × 7 with tag 4, returns 42.
- Reset mid-operation: behaves like the flush scenario, and every output returns to its reset value on the next edge.
